// File: rtl/axis_fan_out.sv
// AXI-stream fan-out: one input stream routed to one of NUM_FANOUT outputs by
// the binary index on s_axis_tuser, optionally locked per packet until tlast.
module axis_fan_out #(
  parameter int NUM_FANOUT     = 6,
  parameter int DATA_WIDTH     = 256,
  parameter int USE_AXIS_TLAST = 1,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  input  logic [NUM_FANOUT-1:0] s_axis_tuser,
  output logic [NUM_FANOUT-1:0] m_axis_tvalid,
  input  logic [NUM_FANOUT-1:0] m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic [CNT_WIDTH-1:0]  drop_count
);

  localparam logic [NUM_FANOUT-1:0] FANOUT_LIMIT = NUM_FANOUT'(NUM_FANOUT);
  localparam bit TLAST_MODE = (USE_AXIS_TLAST != 0);

  typedef enum logic [1:0] {IDLE = 2'd0, FWD = 2'd1, DROP = 2'd2} state_t;

  state_t                  state_reg;
  logic                    out_valid_reg;
  logic [NUM_FANOUT-1:0]   out_sel_reg;
  logic [NUM_FANOUT-1:0]   lock_reg;
  logic [DATA_WIDTH-1:0]   data_reg;
  logic                    last_reg;
  logic [CNT_WIDTH-1:0]    drop_count_reg;

  logic [NUM_FANOUT-1:0]   dest;
  logic [NUM_FANOUT-1:0]   dest_onehot;
  logic                    dest_valid;
  logic                    accept;
  logic                    route;
  logic                    drop_new;
  logic                    out_handshake;

  // Mid-packet beats follow the locked channel; tuser is only looked at in IDLE.
  assign dest       = (state_reg == FWD) ? lock_reg : s_axis_tuser;
  assign dest_valid = (dest < FANOUT_LIMIT);

  generate
    for (genvar gi = 0; gi < NUM_FANOUT; gi++) begin : g_onehot
      assign dest_onehot[gi] = (dest == NUM_FANOUT'(gi));
    end
  endgenerate

  assign out_handshake = out_valid_reg & |(out_sel_reg & m_axis_tready);
  assign s_axis_tready = (state_reg == DROP) | ~out_valid_reg | |(out_sel_reg & m_axis_tready);
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign route         = accept & (state_reg != DROP) & dest_valid;
  // Only the first beat of a bad packet is counted; the rest are swallowed in DROP.
  assign drop_new      = accept & (state_reg == IDLE) & ~dest_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      lock_reg       <= '0;
      out_valid_reg  <= 1'b0;
      out_sel_reg    <= '0;
      data_reg       <= '0;
      last_reg       <= 1'b0;
      drop_count_reg <= '0;
    end else begin
      if (accept && TLAST_MODE) begin
        case (state_reg)
          IDLE: begin
            if (!s_axis_tlast) begin
              state_reg <= dest_valid ? FWD : DROP;
              lock_reg  <= s_axis_tuser;
            end
          end
          FWD, DROP: begin
            if (s_axis_tlast) state_reg <= IDLE;
          end
          default: state_reg <= IDLE;
        endcase
      end

      if (route) begin
        out_valid_reg <= 1'b1;
        out_sel_reg   <= dest_onehot;
        data_reg      <= s_axis_tdata;
        last_reg      <= s_axis_tlast & TLAST_MODE;
      end else if (out_handshake) begin
        out_valid_reg <= 1'b0;
      end

      if (drop_new && (drop_count_reg != '1)) begin
        drop_count_reg <= drop_count_reg + CNT_WIDTH'(1);
      end
    end
  end

  assign m_axis_tvalid = out_valid_reg ? out_sel_reg : '0;
  assign m_axis_tdata  = data_reg;
  assign m_axis_tlast  = last_reg;
  assign drop_count    = drop_count_reg;

endmodule
